// File: rtl/pc_gen_mw.sv
// -----------------------------------------------------------------------------
// pc_gen_mw -- multi-wide fetch-PC generator
//
// Sits at the head of the fetch stage. It issues aligned fetch-block requests
// to the I-cache over a valid/ready handshake. Redirects come from three
// sources: flush, resolved branch and predicted branch. A redirect that
// arrives while the request is frozen (stall or back-pressure) is held in a
// one-entry pending slot, so it is never lost.
//
// Parameters
//   RESET_PC     first fetch address after reset (4-byte aligned)
//   FETCH_WIDTH  instructions per fetch block: 1, 2, 4 or 8
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous active-low reset
//   stall      freezes PC and pending state (redirect capture still allowed)
//   flush      exception/eret redirect to new_pc (highest priority)
//   new_pc     flush target
//   br_e       resolved-branch redirect to br_target
//   br_target  branch target
//   bp_e       predicted-taken redirect to bp_target (lowest priority)
//   bp_target  predicted target
//   req_valid  fetch request valid (stays high after the first post-reset cycle)
//   req_pc     fetch address (the PC register)
//   req_mask   valid instruction slots within the aligned block
//   req_adel   fetch address error (req_pc not word aligned)
//   req_ready  I-cache accepts the request this cycle
// -----------------------------------------------------------------------------
module pc_gen_mw #(
    parameter logic [31:0] RESET_PC    = 32'hbfc0_0000,
    parameter int          FETCH_WIDTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall,
    input  logic                   flush,
    input  logic [31:0]            new_pc,
    input  logic                   br_e,
    input  logic [31:0]            br_target,
    input  logic                   bp_e,
    input  logic [31:0]            bp_target,
    output logic                   req_valid,
    output logic [31:0]            req_pc,
    output logic [FETCH_WIDTH-1:0] req_mask,
    output logic                   req_adel,
    input  logic                   req_ready
);

    localparam int          BLK      = FETCH_WIDTH * 4;
    localparam int          OFF_W    = $clog2(BLK);
    localparam logic [31:0] BLK_SIZE = 32'(BLK);
    localparam logic [31:0] BLK_BASE = ~(BLK_SIZE - 32'd1);

    logic [31:0] pc;
    logic        pend_v;
    logic        pend_bp;
    logic [31:0] pend_pc;

    logic        adv;
    logic        have_redir;
    logic [31:0] tgt;
    logic [31:0] seq;

    // The request may only move when nobody is stalling and the current
    // request (if any) is being taken by the I-cache.
    assign adv = !stall && (!req_valid || req_ready);

    // Next sequential block; the 32-bit add wraps naturally at the top of the
    // address space.
    assign seq = (pc & BLK_BASE) + BLK_SIZE;

    // Redirect selection: flush > branch > pending > prediction > sequential.
    // A pending entry outranks a fresh prediction because it is older.
    always_comb begin
        // NOTE: every always_comb output gets a default before any branch so
        // that no path leaves it unassigned; that is what keeps this a mux and
        // not a latch.
        have_redir = 1'b1;
        tgt        = '0;
        if (flush) begin
            tgt = new_pc;
        end else if (br_e) begin
            tgt = br_target;
        end else if (pend_v) begin
            tgt = pend_pc;
        end else if (bp_e) begin
            tgt = bp_target;
        end else begin
            have_redir = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register in this block samples the pre-edge values of the others.
        if (!rst) begin
            pc        <= RESET_PC;
            req_valid <= 1'b0;
            pend_v    <= 1'b0;
            pend_bp   <= 1'b0;
            pend_pc   <= '0;
        end else if (adv) begin
            if (req_valid) begin
                pc <= have_redir ? tgt : seq;
            end else begin
                // First request after reset: issue the current PC unless a
                // redirect already wants somewhere else.
                req_valid <= 1'b1;
                if (have_redir) begin
                    pc <= tgt;
                end
            end
            pend_v  <= 1'b0;
            pend_bp <= 1'b0;
        end else begin
            // Request frozen: remember the redirect for the next advance.
            // Flush/branch always overwrite; a prediction may only fill an
            // empty slot or replace an older prediction.
            if (flush || br_e) begin
                pend_v  <= 1'b1;
                pend_bp <= 1'b0;
                pend_pc <= flush ? new_pc : br_target;
            end else if (bp_e && (!pend_v || pend_bp)) begin
                pend_v  <= 1'b1;
                pend_bp <= 1'b1;
                pend_pc <= bp_target;
            end
        end
    end

    assign req_pc   = pc;
    assign req_adel = pc[0] | pc[1];

    generate
        if (FETCH_WIDTH == 1) begin : g_single
            assign req_mask = 1'b1;
        end else begin : g_multi
            int slot;

            // Slots before the entry point of the block are not fetched. A
            // misaligned PC only marks its own slot so the exception is taken
            // on exactly one instruction.
            always_comb begin
                slot     = int'(pc[OFF_W-1:2]);
                req_mask = '0;
                for (int i = 0; i < FETCH_WIDTH; i++) begin
                    req_mask[i] = req_adel ? (i == slot) : (i >= slot);
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_pc_gen_mw.sv
// -----------------------------------------------------------------------------
// tb_pc_gen_mw -- self-checking bench for pc_gen_mw
//
// Two instances (FETCH_WIDTH 2 and 4) share one directed stimulus stream. A
// behavioural model tracks what each must present; a compare process checks
// every output on every falling edge, and the stimulus adds hand-computed
// literal expectations at the interesting points.
// -----------------------------------------------------------------------------
module tb_pc_gen_mw;

    localparam logic [31:0] RST_PC = 32'hbfc0_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, stall, flush, br_e, bp_e, req_ready;
    logic [31:0] new_pc, br_target, bp_target;

    logic        v2, a2, v4, a4;
    logic [31:0] pc2, pc4;
    logic [1:0]  m2;
    logic [3:0]  m4;

    pc_gen_mw #(.RESET_PC(RST_PC), .FETCH_WIDTH(2)) u_fw2 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .new_pc(new_pc),
        .br_e(br_e), .br_target(br_target), .bp_e(bp_e), .bp_target(bp_target),
        .req_valid(v2), .req_pc(pc2), .req_mask(m2), .req_adel(a2),
        .req_ready(req_ready)
    );

    pc_gen_mw #(.RESET_PC(RST_PC), .FETCH_WIDTH(4)) u_fw4 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .new_pc(new_pc),
        .br_e(br_e), .br_target(br_target), .bp_e(bp_e), .bp_target(bp_target),
        .req_valid(v4), .req_pc(pc4), .req_mask(m4), .req_adel(a4),
        .req_ready(req_ready)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------------------------------------------------------- model
    // Index 0 models the 2-wide instance, index 1 the 4-wide one.
    logic [31:0] m_pc[2];
    logic [31:0] m_held_pc[2];
    bit          m_valid[2];
    bit          m_held[2];      // a redirect is waiting for the next advance
    bit          m_held_pred[2]; // ... and it came from the predictor
    bit          live = 1'b0;

    function automatic int width_of(int k);
        return (k == 0) ? 2 : 4;
    endfunction

    // Start of the following aligned block, modulo 2^32.
    function automatic logic [31:0] next_block(logic [31:0] pc, int fw);
        longint unsigned p   = longint'(pc);
        longint unsigned blk = longint'(fw * 4);
        longint unsigned nb  = (p - (p % blk) + blk) % 64'h1_0000_0000;
        return nb[31:0];
    endfunction

    function automatic logic [31:0] expect_mask(logic [31:0] pc, int fw);
        longint unsigned p = longint'(pc);
        int          s   = int'((p % longint'(fw * 4)) / 4);
        bit          mis = (p % 4) != 0;
        logic [31:0] m   = '0;
        for (int i = 0; i < fw; i++) begin
            m[i] = mis ? (i == s) : (i >= s);
        end
        return m;
    endfunction

    task automatic step(int k);
        bit          moving;
        bit          go_elsewhere;
        logic [31:0] dest;
        if (!rst) begin
            m_pc[k]        = RST_PC;
            m_valid[k]     = 1'b0;
            m_held[k]      = 1'b0;
            m_held_pred[k] = 1'b0;
            m_held_pc[k]   = '0;
            live           = 1'b1;
            return;
        end
        moving       = !stall && (!m_valid[k] || req_ready);
        go_elsewhere = 1'b1;
        dest         = '0;
        if (flush)          dest = new_pc;
        else if (br_e)      dest = br_target;
        else if (m_held[k]) dest = m_held_pc[k];
        else if (bp_e)      dest = bp_target;
        else                go_elsewhere = 1'b0;

        if (moving) begin
            if (m_valid[k])        m_pc[k] = go_elsewhere ? dest : next_block(m_pc[k], width_of(k));
            else if (go_elsewhere) m_pc[k] = dest;
            m_valid[k]     = 1'b1;
            m_held[k]      = 1'b0;
            m_held_pred[k] = 1'b0;
        end else if (flush || br_e) begin
            m_held[k]      = 1'b1;
            m_held_pred[k] = 1'b0;
            m_held_pc[k]   = flush ? new_pc : br_target;
        end else if (bp_e && (!m_held[k] || m_held_pred[k])) begin
            m_held[k]      = 1'b1;
            m_held_pred[k] = 1'b1;
            m_held_pc[k]   = bp_target;
        end
    endtask

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) step(k);
    end

    // -------------------------------------------------------------- compare
    always @(negedge clk) begin
        if (live) begin
            check("fw2 req_valid", 32'(v2), 32'(m_valid[0]));
            check("fw2 req_pc",    pc2,     m_pc[0]);
            check("fw2 req_mask",  32'(m2), expect_mask(m_pc[0], 2));
            check("fw2 req_adel",  32'(a2), 32'(m_pc[0][1:0] != 2'b00));
            check("fw4 req_valid", 32'(v4), 32'(m_valid[1]));
            check("fw4 req_pc",    pc4,     m_pc[1]);
            check("fw4 req_mask",  32'(m4), expect_mask(m_pc[1], 4));
            check("fw4 req_adel",  32'(a4), 32'(m_pc[1][1:0] != 2'b00));
        end
    end

    // ------------------------------------------------------------- stimulus
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; stall = 1'b0; flush = 1'b0; br_e = 1'b0; bp_e = 1'b0;
        req_ready = 1'b1; new_pc = '0; br_target = '0; bp_target = '0;

        // Reset and release.
        tick();
        check("rst valid",    32'(v2), 32'd0);
        check("rst pc",       pc2, RST_PC);
        rst = 1'b1;
        tick();
        check("first valid",  32'(v2), 32'd1);
        check("first pc",     pc2, 32'hbfc0_0000);
        check("first mask2",  32'(m2), 32'h3);
        check("first mask4",  32'(m4), 32'hf);
        tick();
        check("seq pc2",      pc2, 32'hbfc0_0008);
        check("seq pc4",      pc4, 32'hbfc0_0010);

        // Branch with advance.
        br_e = 1'b1; br_target = 32'h8000_0014;
        tick();
        br_e = 1'b0;
        check("br pc4",       pc4, 32'h8000_0014);
        check("br mask4",     32'(m4), 32'he);
        check("br mask2",     32'(m2), 32'h2);
        tick();
        check("br seq pc4",   pc4, 32'h8000_0020);
        check("br seq pc2",   pc2, 32'h8000_0018);

        // Back-pressure: branch then prediction while held.
        req_ready = 1'b0;
        br_e = 1'b1; br_target = 32'h0000_0100;
        tick();
        br_e = 1'b0;
        check("bp hold 1",    pc4, 32'h8000_0020);
        bp_e = 1'b1; bp_target = 32'h0000_0200;
        tick();
        bp_e = 1'b0;
        check("bp hold 2",    pc4, 32'h8000_0020);
        tick();
        check("bp hold 3",    pc4, 32'h8000_0020);
        req_ready = 1'b1;
        tick();
        check("held br pc4",  pc4, 32'h0000_0100);
        check("held br pc2",  pc2, 32'h0000_0100);

        // Stall with pending prediction, then flush while still stalled.
        stall = 1'b1;
        bp_e = 1'b1; bp_target = 32'h0000_0200;
        tick();
        bp_e = 1'b0;
        flush = 1'b1; new_pc = 32'hbfc0_0380;
        tick();
        flush = 1'b0;
        check("stall hold",   pc2, 32'h0000_0100);
        tick();
        stall = 1'b0;
        tick();
        check("stall flush",  pc2, 32'hbfc0_0380);
        check("stall fl m4",  32'(m4), 32'hf);

        // Flush beats branch in the same cycle.
        flush = 1'b1; new_pc = 32'h0000_0040;
        br_e  = 1'b1; br_target = 32'h0000_0080;
        tick();
        br_e = 1'b0;
        check("flush>br",     pc4, 32'h0000_0040);

        // Misaligned targets.
        new_pc = 32'h0000_1002;
        tick();
        check("adel",         32'(a4), 32'd1);
        check("adel mask4",   32'(m4), 32'h1);
        check("adel mask2",   32'(m2), 32'h1);
        new_pc = 32'h0000_100e;
        tick();
        flush = 1'b0;
        check("adel e mask4", 32'(m4), 32'h8);
        check("adel e mask2", 32'(m2), 32'h2);
        tick();
        check("mis seq pc2",  pc2, 32'h0000_1010);
        check("mis seq pc4",  pc4, 32'h0000_1010);

        // Wrap at the top of the address space.
        flush = 1'b1; new_pc = 32'hffff_fff8;
        tick();
        flush = 1'b0;
        check("top mask4",    32'(m4), 32'hc);
        tick();
        check("wrap pc2",     pc2, 32'h0000_0000);
        check("wrap pc4",     pc4, 32'h0000_0000);

        // Reset mid-stall with a pending redirect; reset beats flush.
        stall = 1'b1;
        br_e = 1'b1; br_target = 32'h0000_0500;
        tick();
        br_e = 1'b0;
        rst = 1'b0;
        flush = 1'b1; new_pc = 32'h0000_0700;
        tick();
        flush = 1'b0;
        check("mid rst valid", 32'(v4), 32'd0);
        check("mid rst pc",    pc4, RST_PC);
        rst = 1'b1; stall = 1'b0;
        tick();
        check("restart valid", 32'(v4), 32'd1);
        check("restart pc",    pc4, RST_PC);
        tick();
        check("restart seq",   pc2, 32'hbfc0_0008);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_gen_mw.md
Name: pc_gen_mw

Overview:
Parametrised fetch-PC generator, the successor of the single-issue PC register. It sits at the head of the fetch stage and issues aligned multi-instruction fetch requests to the I-cache over a valid/ready handshake. Redirects come from flush, branch resolution and branch prediction. Unlike the previous generation, it never drops a redirect that arrives while stalled or back-pressured.

Parameters:
RESET_PC, 32'hbfc0_0000, address of the first fetch after reset; must be 4-byte aligned.
FETCH_WIDTH, 2, instructions per fetch block; legal values are 1, 2, 4 or 8. Block size BLK = FETCH_WIDTH*4 bytes.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  synchronous, active-low reset; rst==0 at a rising edge resets the block.
stall  in  1  pipeline stall; 1 freezes the PC and pending state (redirect capture still allowed).
flush  in  1  exception/eret redirect, highest priority.
new_pc  in  32  flush target.
br_e  in  1  resolved-branch redirect.
br_target  in  32  branch target.
bp_e  in  1  predicted-taken redirect, lowest redirect priority.
bp_target  in  32  predicted target.
req_valid  out  1  fetch request valid.
req_pc  out  32  fetch address (the PC register).
req_mask  out  FETCH_WIDTH  valid instruction slots within the aligned block.
req_adel  out  1  fetch address error: req_pc[1:0]!=0.
req_ready  in  1  I-cache accepts the request this cycle.

Behaviour:
- Reset (rst==0 at an edge): pc<=RESET_PC, req_valid<=0, pend_v<=0, pend_bp<=0, pend_pc<=0. Reset overrides every other input.
- adv = !stall && (!req_valid || req_ready). The request is held stable while req_valid && (!req_ready || stall); no output may change then.
- Redirect selection for the cycle:
  - priority is flush > br_e > pend_v > bp_e > sequential;
  - the selected target is tgt; the sequential target is seq = (pc & ~(BLK-1)) + BLK, computed modulo 2^32 (wraps 0xffff_fff8 -> 0x0).
- On adv with req_valid==1:
  - pc<=tgt, else seq;
  - pend_v<=0.
- On adv with req_valid==0 (first cycle after reset):
  - req_valid<=1;
  - pc<=tgt if a redirect is selected, else pc is unchanged;
  - pend cleared.
  - req_valid never falls again except on reset.
- When !adv:
  - flush or br_e loads pend_v<=1, pend_pc<=(flush?new_pc:br_target), pend_bp<=0. This overwrites any earlier pending entry.
  - bp_e (without flush/br_e) loads pend_v<=1, pend_bp<=1, pend_pc<=bp_target only if pend_v==0 or pend_bp==1. It never displaces a flush or branch entry.
- req_mask:
  - slot index s = pc[log2(BLK)-1:2]; bit i is 1 iff i>=s;
  - when req_adel==1, req_mask is one-hot at s;
  - with FETCH_WIDTH==1, req_mask is constantly 1.
- req_adel = pc[0]|pc[1], combinational from the pc register.
- Latency: a redirect presented on a cycle with adv appears on req_pc the next cycle. A redirect presented during a stall appears on the first cycle after the first adv.
- Redirects with flush/br/bp all low and no pending leave pend unchanged.

Test Plan:
- Reset then release, FETCH_WIDTH=2, req_ready=1 -> cycle 1: req_valid=1, req_pc=0xbfc0_0000, mask=2'b11; cycle 2: req_pc=0xbfc0_0008.
- Branch to 0x8000_0014 with adv, FETCH_WIDTH=4 -> next req_pc=0x8000_0014, mask=4'b1110; following req_pc=0x8000_0020.
- req_ready=0 for 3 cycles, br_e pulse (target 0x100) in cycle 1, then bp_e (target 0x200) in cycle 2 -> req_pc held for all 3 cycles; after acceptance req_pc=0x100, with pend_bp ignored.
- Stall with pending bp 0x200, then flush new_pc=0xbfc0_0380 while still stalled -> after release req_pc=0xbfc0_0380.
- Flush and br_e in the same adv cycle -> new_pc wins; flush to 0x1002 -> req_adel=1, mask one-hot at the slot index.
- Sequential wrap from 0xffff_fff8 with FETCH_WIDTH=2 -> next req_pc=0x0; rst=0 mid-stall with pending redirect -> req_valid=0, pend cleared, restart at RESET_PC.
